// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet receiver:
// FSM states, error codes, frame/packet geometry and a parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BYTE_DONE
   } ps2_state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_PARITY  = 3'd1;
   localparam logic [2:0] ERR_STOP    = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_SYNC    = 3'd4;

   // start + 8 data + parity + stop
   localparam int PS2_FRAME_BITS = 11;
   localparam int PKT_BYTES      = 3;
   // byte0 bit that is always 1 in a PS/2 mouse packet
   localparam int SYNC_BIT       = 3;

   // Odd parity: data bits together with the parity bit hold an odd number of ones.
   function automatic logic parity_ok(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin front end: 2-FF synchronizers on clock and data, stability filter on clock.
// Ports: ck, reset | ps2_clk, ps2_data (raw pins) | fall (1-cycle pulse), data (aligned sample).
module ps2_clk_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic ck,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_s;
   logic [1:0]    dat_s;
   logic          clk_f;
   logic [CW-1:0] cnt;

   // A new level on the synchronized clock is accepted only after it has
   // differed from the filtered level for FILTER_LEN consecutive cycles.
   // fall and data are registered together so data is the value present
   // when the falling edge was accepted.
   always_ff @(posedge ck) begin
      if (reset) begin
         clk_s <= 2'b11;
         dat_s <= 2'b11;
         clk_f <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
         data  <= 1'b1;
      end else begin
         clk_s <= {clk_s[0], ps2_clk};
         dat_s <= {dat_s[0], ps2_data};
         data  <= dat_s[1];
         fall  <= 1'b0;
         if (clk_s[1] == clk_f) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            cnt   <= '0;
            clk_f <= clk_s[1];
            fall  <= clk_f;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_mouse_pkt_ctrl.sv
// PS/2 mouse receiver: frames 11-bit words, checks start/parity/stop, builds 3-byte packets.
// Ports: ck, reset | ps2_clk, ps2_data | pkt_valid, pkt_data, btn, dx, dy | err, err_code, busy.
module ps2_mouse_pkt_ctrl
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 3400
) (
   input  logic        ck,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic        pkt_valid,
   output logic [23:0] pkt_data,
   output logic [2:0]  btn,
   output logic [8:0]  dx,
   output logic [8:0]  dy,
   output logic        err,
   output logic [2:0]  err_code,
   output logic        busy
);

   localparam int         DATA_BITS = PS2_FRAME_BITS - 3;
   localparam int         WDW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [1:0] LAST_IDX  = 2'(PKT_BYTES - 1);

   logic fall;
   logic sdata;

   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filt (
      .ck       (ck),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .fall     (fall),
      .data     (sdata)
   );

   ps2_state_t     state, state_n;
   logic [2:0]     bitcnt, bitcnt_n;
   logic [7:0]     shreg, shreg_n;
   logic           par, par_n;
   logic [1:0]     idx, idx_n;
   logic [7:0]     b0, b0_n;
   logic [7:0]     b1, b1_n;
   logic [WDW-1:0] wd, wd_n;
   logic           err_n;
   logic [2:0]     code_n;
   logic           pv_n;
   logic [23:0]    pkt_n;

   always_ff @(posedge ck) begin
      if (reset) begin
         state     <= ST_IDLE;
         bitcnt    <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         idx       <= '0;
         b0        <= '0;
         b1        <= '0;
         wd        <= '0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         pkt_valid <= 1'b0;
         pkt_data  <= '0;
      end else begin
         state     <= state_n;
         bitcnt    <= bitcnt_n;
         shreg     <= shreg_n;
         par       <= par_n;
         idx       <= idx_n;
         b0        <= b0_n;
         b1        <= b1_n;
         wd        <= wd_n;
         err       <= err_n;
         err_code  <= code_n;
         pkt_valid <= pv_n;
         pkt_data  <= pkt_n;
      end
   end

   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      shreg_n  = shreg;
      par_n    = par;
      idx_n    = idx;
      b0_n     = b0;
      b1_n     = b1;
      wd_n     = wd;
      err_n    = 1'b0;
      code_n   = err_code;
      pv_n     = 1'b0;
      pkt_n    = pkt_data;

      unique case (state)
         ST_IDLE: begin
            // a high level on an edge is line noise, not a start bit
            if (fall && !sdata) begin
               state_n  = ST_DATA;
               bitcnt_n = '0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shreg_n  = {sdata, shreg[7:1]};
               bitcnt_n = bitcnt + 1'b1;
               if (bitcnt == 3'(DATA_BITS - 1)) begin
                  state_n = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (fall) begin
               par_n   = sdata;
               state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               if (!parity_ok(shreg, par)) begin
                  err_n   = 1'b1;
                  code_n  = ERR_PARITY;
                  idx_n   = '0;
                  state_n = ST_IDLE;
               end else if (!sdata) begin
                  err_n   = 1'b1;
                  code_n  = ERR_STOP;
                  idx_n   = '0;
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_BYTE_DONE;
               end
            end
         end
         ST_BYTE_DONE: begin
            state_n = ST_IDLE;
            if (idx == '0 && !shreg[SYNC_BIT]) begin
               // misaligned first byte: drop it and keep hunting for byte0
               err_n  = 1'b1;
               code_n = ERR_SYNC;
            end else if (idx == LAST_IDX) begin
               pv_n  = 1'b1;
               pkt_n = {b0, b1, shreg};
               idx_n = '0;
            end else begin
               if (idx == '0) begin
                  b0_n = shreg;
               end else begin
                  b1_n = shreg;
               end
               idx_n = idx + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // An edge always restarts the watchdog, so it beats a coincident timeout.
      // BYTE_DONE is never aborted so err and pkt_valid cannot collide; the
      // >= lets a count that passed the limit there expire on the next cycle.
      if (fall || (state == ST_IDLE && idx == '0)) begin
         wd_n = '0;
      end else if (state != ST_BYTE_DONE &&
                   wd >= WDW'(TIMEOUT_CYC - 1)) begin
         wd_n    = '0;
         state_n = ST_IDLE;
         idx_n   = '0;
         err_n   = 1'b1;
         code_n  = ERR_TIMEOUT;
      end else begin
         wd_n = wd + 1'b1;
      end
   end

   assign btn  = pkt_data[18:16];
   assign dx   = {pkt_data[20], pkt_data[15:8]};
   assign dy   = {pkt_data[21], pkt_data[7:0]};
   assign busy = (state != ST_IDLE) || (idx != '0);

endmodule

// File: tb/tb_ps2_mouse_pkt_ctrl.sv
// Self-checking bench for ps2_mouse_pkt_ctrl: byte-level packet model plus
// directed frames covering packets, glitches, frame errors, sync, timeout and reset.
module tb_ps2_mouse_pkt_ctrl;

   localparam int TIMEOUT_CYC = 3400;

   logic        ck = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        pkt_valid;
   logic [23:0] pkt_data;
   logic [2:0]  btn;
   logic [8:0]  dx;
   logic [8:0]  dy;
   logic        err;
   logic [2:0]  err_code;
   logic        busy;

   ps2_mouse_pkt_ctrl #(
      .FILTER_LEN  (4),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .ck        (ck),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .pkt_valid (pkt_valid),
      .pkt_data  (pkt_data),
      .btn       (btn),
      .dx        (dx),
      .dy        (dy),
      .err       (err),
      .err_code  (err_code),
      .busy      (busy)
   );

   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        is_err;
      logic [2:0]  code;
      logic [23:0] pkt;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        cur;
   int         m_idx = 0;
   logic [7:0] m_bytes [3];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_err(input logic [2:0] code);
      exp_q.push_back({1'b1, code, 24'h0});
   endtask

   // Byte-level view of the receiver: what each complete frame must produce.
   task automatic model_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop);
      if (bad_par) begin
         push_err(3'd1);
         m_idx = 0;
      end else if (bad_stop) begin
         push_err(3'd2);
         m_idx = 0;
      end else if (m_idx == 0 && b[3] == 1'b0) begin
         push_err(3'd4);
      end else begin
         m_bytes[m_idx] = b;
         if (m_idx == 2) begin
            exp_q.push_back({1'b0, 3'd0,
                             m_bytes[0], m_bytes[1], m_bytes[2]});
            m_idx = 0;
         end else begin
            m_idx++;
         end
      end
   endtask

   // Every output pulse must match the oldest outstanding expected event.
   always @(negedge ck) begin
      if (!reset && (err || pkt_valid)) begin
         chk("err_and_pkt_valid", {31'b0, err & pkt_valid}, 32'h0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'b0, err, pkt_valid}, 32'h0);
         end else begin
            cur = exp_q.pop_front();
            chk("event_kind", {31'b0, err}, {31'b0, cur.is_err});
            if (cur.is_err) begin
               chk("err_code", {29'b0, err_code}, {29'b0, cur.code});
            end else begin
               chk("pkt_data", {8'b0, pkt_data}, {8'b0, cur.pkt});
               chk("btn", {29'b0, btn}, {29'b0, cur.pkt[18:16]});
               chk("dx", {23'b0, dx}, {23'b0, cur.pkt[20], cur.pkt[15:8]});
               chk("dy", {23'b0, dy}, {23'b0, cur.pkt[21], cur.pkt[7:0]});
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge ck);
   endtask

   task automatic send_bit(input logic v, input bit glitch);
      ps2_data = v;
      cyc(10);
      ps2_clk = 1'b0;
      cyc(20);
      ps2_clk = 1'b1;
      if (glitch) begin
         cyc(8);
         ps2_clk = 1'b0;
         cyc(2);
         ps2_clk = 1'b1;
         cyc(4);
      end else begin
         cyc(14);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int glitch_bit,
                             input int nbits);
      logic [10:0] fr;
      fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      if (nbits == 11) model_frame(b, bad_par, bad_stop);
      for (int i = 0; i < nbits; i++) begin
         send_bit(fr[i], i == glitch_bit);
      end
      ps2_data = 1'b1;
      cyc(60);
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, -1, 11);
   endtask

   task automatic drained(input string name);
      chk(name, exp_q.size(), 32'h0);
   endtask

   initial begin
      cyc(3);
      @(negedge ck);
      chk("rst_pkt_valid", {31'b0, pkt_valid}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_err_code", {29'b0, err_code}, 32'h0);
      chk("rst_pkt_data", {8'b0, pkt_data}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_dx", {23'b0, dx}, 32'h0);
      reset = 1'b0;
      cyc(20);

      // basic packet
      good(8'h09);
      good(8'h05);
      good(8'hFB);
      drained("pkt1_drained");
      chk("pkt1_data", {8'b0, pkt_data}, 32'h0905FB);
      chk("pkt1_btn", {29'b0, btn}, 32'h1);
      chk("pkt1_dx", {23'b0, dx}, 32'h005);
      chk("pkt1_dy", {23'b0, dy}, 32'h0FB);
      chk("pkt1_busy", {31'b0, busy}, 32'h0);

      // Y sign bit set in byte0 -> dy = -5
      good(8'h29);
      good(8'h05);
      good(8'hFB);
      drained("pkt2_drained");
      chk("pkt2_dx", {23'b0, dx}, 32'h005);
      chk("pkt2_dy", {23'b0, dy}, 32'h1FB);

      // short clock glitch inside a frame
      good(8'h08);
      send_frame(8'h12, 1'b0, 1'b0, 4, 11);
      good(8'h34);
      drained("glitch_drained");
      chk("glitch_pkt", {8'b0, pkt_data}, 32'h081234);

      // parity error on byte0, then recovery
      send_frame(8'h08, 1'b1, 1'b0, -1, 11);
      drained("par_drained");
      chk("par_code", {29'b0, err_code}, 32'h1);
      chk("par_busy", {31'b0, busy}, 32'h0);
      good(8'h18);
      good(8'h10);
      good(8'h20);
      drained("par_rec_drained");
      chk("par_rec_pkt", {8'b0, pkt_data}, 32'h181020);

      // stop error mid-packet discards the partial packet
      good(8'h08);
      send_frame(8'h0C, 1'b0, 1'b1, -1, 11);
      drained("stop_drained");
      chk("stop_code", {29'b0, err_code}, 32'h2);
      chk("stop_busy", {31'b0, busy}, 32'h0);

      // misaligned first byte
      good(8'h00);
      drained("sync_drained");
      chk("sync_code", {29'b0, err_code}, 32'h4);
      chk("sync_busy", {31'b0, busy}, 32'h0);
      good(8'h08);
      good(8'h01);
      good(8'h02);
      drained("sync_rec_drained");
      chk("sync_rec_pkt", {8'b0, pkt_data}, 32'h080102);

      // partial frame then clock held high
      push_err(3'd3);
      m_idx = 0;
      send_frame(8'h55, 1'b0, 1'b0, -1, 7);
      chk("to_busy_before", {31'b0, busy}, 32'h1);
      cyc(TIMEOUT_CYC + 100);
      drained("to_drained");
      chk("to_code", {29'b0, err_code}, 32'h3);
      chk("to_busy_after", {31'b0, busy}, 32'h0);
      good(8'h0A);
      good(8'h03);
      good(8'h04);
      drained("to_rec_drained");
      chk("to_rec_pkt", {8'b0, pkt_data}, 32'h0A0304);

      // reset after byte1
      good(8'h08);
      good(8'h11);
      chk("rst2_busy_before", {31'b0, busy}, 32'h1);
      reset = 1'b1;
      m_idx = 0;
      cyc(2);
      @(negedge ck);
      chk("rst2_pkt_data", {8'b0, pkt_data}, 32'h0);
      chk("rst2_err_code", {29'b0, err_code}, 32'h0);
      chk("rst2_busy", {31'b0, busy}, 32'h0);
      chk("rst2_pulses", {30'b0, err, pkt_valid}, 32'h0);
      reset = 1'b0;
      cyc(20);
      good(8'h38);
      good(8'h7F);
      good(8'h80);
      drained("rst2_rec_drained");
      chk("rst2_rec_pkt", {8'b0, pkt_data}, 32'h387F80);
      chk("rst2_rec_dx", {23'b0, dx}, 32'h17F);
      chk("rst2_rec_dy", {23'b0, dy}, 32'h180);
      chk("rst2_rec_code", {29'b0, err_code}, 32'h0);

      cyc(20);
      drained("final_drained");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
